pipe_stage_elastic: RTL and testbench

- Parametrised elastic pipeline stage register. Successor to the fixed-field stage registers between decode/execute/memory.
- Carries an opaque DATA_WIDTH payload, which is the packed control and data fields of one stage, under a valid/ready handshake.
- A 2-entry skid buffer gives full throughput and a registered-path backpressure.
- Synchronous flush inserts a programmable bubble, replacing the old stall-as-flush coupling: hold and squash are now separate events.

---
 rtl/pipe_stage_elastic_if.sv | 41 ++++
 rtl/pipe_stage_elastic.sv | 129 ++++++++++++
 tb/tb_pipe_stage_elastic.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/pipe_stage_elastic_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_elastic_if
// Brief    : Valid/ready handshake bundle (upstream + downstream + flush)
//            for one elastic pipeline stage.
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_stage_elastic_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;

    // Environment side: produces upstream traffic, consumes downstream.
    modport master (
        output flush,
        output in_valid,
        input  in_ready,
        output in_data,
        input  out_valid,
        output out_ready,
        input  out_data
    );

    // Stage side.
    modport slave (
        input  flush,
        input  in_valid,
        output in_ready,
        input  in_data,
        output out_valid,
        input  out_ready,
        output out_data
    );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_elastic.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_elastic
// Brief    : Elastic pipeline stage register with 2-entry skid buffer and
//            synchronous flush that inserts BUBBLE_VALUE.
//            Optional macro PIPE_STAGE_PERF_EN adds the stall_cnt port.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_elastic #(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] BUBBLE_VALUE = '0,
    parameter int                    CNT_WIDTH    = 16
) (
    input  wire logic           clk,
    input  wire logic           rst,
    pipe_stage_elastic_if.slave bus
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_main;
    logic [DATA_WIDTH-1:0] r_skid;
    logic [DATA_WIDTH-1:0] w_main_nxt;
    logic [DATA_WIDTH-1:0] w_skid_nxt;
    logic                  w_in_ready;
    logic                  w_out_valid;
    logic                  w_in_fire;
    logic                  w_out_fire;

    if (DATA_WIDTH < 1 || CNT_WIDTH < 1) begin : g_bad_params
        $error("pipe_stage_elastic: DATA_WIDTH and CNT_WIDTH must be >= 1");
    end

    // in_ready is a function of registered state only, so out_ready never
    // reaches it combinationally.
    assign w_in_ready  = !rst && !bus.flush && (r_state != TWO);
    assign w_out_valid = !bus.flush && (r_state != EMPTY);
    assign w_in_fire   = bus.in_valid && w_in_ready;
    assign w_out_fire  = w_out_valid && bus.out_ready;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = r_main;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
            r_main  <= BUBBLE_VALUE;
            r_skid  <= BUBBLE_VALUE;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (bus.flush) begin
            w_state_nxt = EMPTY;
            w_main_nxt  = BUBBLE_VALUE;
            w_skid_nxt  = BUBBLE_VALUE;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt = ONE;
                        w_main_nxt  = bus.in_data;
                    end
                end
                ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_nxt = bus.in_data;
                    end else if (w_in_fire) begin
                        w_state_nxt = TWO;
                        w_skid_nxt  = bus.in_data;
                    end else if (w_out_fire) begin
                        w_state_nxt = EMPTY;
                        w_main_nxt  = BUBBLE_VALUE;
                    end
                end
                TWO: begin
                    // Skid entry moves up to the head; skid slot returns to bubble.
                    if (w_out_fire) begin
                        w_state_nxt = ONE;
                        w_main_nxt  = r_skid;
                        w_skid_nxt  = BUBBLE_VALUE;
                    end
                end
                default: begin
                    w_state_nxt = EMPTY;
                    w_main_nxt  = BUBBLE_VALUE;
                    w_skid_nxt  = BUBBLE_VALUE;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] r_stall_cnt;

    // Saturating; only rst clears it so stalls survive a flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_out_valid && !bus.out_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + c_cnt_one;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_elastic.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_elastic
// Brief    : Self-checking bench for pipe_stage_elastic against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_elastic;

    localparam int             DW  = 32;
    localparam logic [DW-1:0]  BUB = 32'hBFC0_0000;
    localparam int             CW  = 4;

    logic clk = 1'b0;
    logic rst;

    pipe_stage_elastic_if #(.DATA_WIDTH(DW)) bus ();

`ifdef PIPE_STAGE_PERF_EN
    logic [CW-1:0] stall_cnt;
    int            stall_model = 0;
`endif

    pipe_stage_elastic #(
        .DATA_WIDTH   (DW),
        .BUBBLE_VALUE (BUB),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] q[$];
    bit            known  = 1'b0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive, check pre-edge outputs against the queue, advance the queue.
    task automatic step(input logic r, input logic f, input logic iv,
                        input logic [DW-1:0] d, input logic ordy);
        logic          e_ir;
        logic          e_ov;
        logic [DW-1:0] e_data;
        rst           = r;
        bus.flush     = f;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        e_ir   = !r && !f && (q.size() < 2);
        e_ov   = !f && (q.size() > 0);
        e_data = (q.size() > 0) ? q[0] : BUB;
        @(negedge clk);
        chk("in_ready", DW'(bus.in_ready), DW'(e_ir));
        if (known) begin
            chk("out_valid", DW'(bus.out_valid), DW'(e_ov));
            chk("out_data", bus.out_data, e_data);
`ifdef PIPE_STAGE_PERF_EN
            chk("stall_cnt", DW'(stall_cnt), DW'(stall_model));
`endif
        end
        @(posedge clk);
        if (r) begin
            q.delete();
            known = 1'b1;
`ifdef PIPE_STAGE_PERF_EN
            stall_model = 0;
`endif
        end else if (known) begin
`ifdef PIPE_STAGE_PERF_EN
            if (e_ov && !ordy && stall_model < (2**CW - 1)) stall_model++;
`endif
            if (f) begin
                q.delete();
            end else begin
                if (e_ov && ordy) void'(q.pop_front());
                if (iv && e_ir) q.push_back(d);
            end
        end
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset with traffic offered
        step(1, 0, 1, 'hAA, 0);
        step(1, 0, 1, 'hAA, 0);

        // Streaming
        step(0, 0, 1, 'h1, 1);
        step(0, 0, 1, 'h2, 1);
        step(0, 0, 1, 'h3, 1);
        step(0, 0, 0, 'h0, 1);
        step(0, 0, 0, 'h0, 1);

        // Backpressure into TWO, then release
        step(0, 0, 1, 'h10, 0);
        step(0, 0, 1, 'h11, 0);
        step(0, 0, 1, 'h12, 0);
        step(0, 0, 1, 'h12, 1);
        step(0, 0, 1, 'h12, 1);
        step(0, 0, 0, 'h0, 1);
        step(0, 0, 0, 'h0, 1);

        // Flush while full
        step(0, 0, 1, 'h20, 0);
        step(0, 0, 1, 'h21, 0);
        step(0, 1, 1, 'h22, 0);
        step(0, 0, 0, 'h0, 1);
        step(0, 0, 0, 'h0, 1);

        // Drain
        step(0, 0, 1, 'h30, 1);
        step(0, 0, 0, 'h0, 1);
        step(0, 0, 0, 'h0, 1);

        // Long stall, flush, then reset
        step(0, 0, 1, 'h40, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 'h0, 0);
        step(0, 1, 0, 'h0, 0);
        step(0, 0, 0, 'h0, 0);
        step(1, 0, 0, 'h0, 0);
        step(0, 0, 0, 'h0, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 31) == 0),
                 1'($urandom), DW'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
